// File: rtl/clock_time_ctrl.sv
// Sequencer for a chained BCD HH:MM:SS (24 h) time-of-day counter.
// A prescaler produces a once-per-second advance; a button-driven mode
// machine lets the user set hours, then minutes.
module clock_time_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic [3:0] hr_lo,
  output logic [3:0] hr_hi,
  output logic [1:0] mode,
  output logic       tick,
  output logic       day_co
);

  localparam int unsigned   PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_e;

  mode_e         state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sec_lo_q, sec_lo_d, sec_hi_q, sec_hi_d;
  logic [3:0]    min_lo_q, min_lo_d, min_hi_q, min_hi_d;
  logic [3:0]    hr_lo_q, hr_lo_d, hr_hi_q, hr_hi_d;
  logic          tick_q, tick_d, day_co_q, day_co_d;

  logic pre_wrap, sec_wrap, min_wrap, hr_wrap;
  logic inc_min, inc_hr;

  assign pre_wrap = (presc_q == PRE_LAST);
  assign sec_wrap = (sec_hi_q == 4'd5) && (sec_lo_q == 4'd9);
  assign min_wrap = (min_hi_q == 4'd5) && (min_lo_q == 4'd9);
  assign hr_wrap  = (hr_hi_q == 4'd2) && (hr_lo_q == 4'd3);

  // Mode transitions, prescaler and the full digit carry chain.
  // Minute and hour increments are requested by either the running carry
  // chain or the set buttons, and applied by one shared update below.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    sec_lo_d = sec_lo_q;
    sec_hi_d = sec_hi_q;
    min_lo_d = min_lo_q;
    min_hi_d = min_hi_q;
    hr_lo_d  = hr_lo_q;
    hr_hi_d  = hr_hi_q;
    tick_d   = 1'b0;
    day_co_d = 1'b0;
    inc_min  = 1'b0;
    inc_hr   = 1'b0;

    case (state_q)
      RUN: begin
        if (btn_mode) state_d = SET_HR;
        if (run_en) begin
          if (pre_wrap) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (sec_lo_q != 4'd9) begin
              sec_lo_d = sec_lo_q + 4'd1;
            end else begin
              sec_lo_d = '0;
              sec_hi_d = (sec_hi_q == 4'd5) ? 4'd0 : sec_hi_q + 4'd1;
            end
            inc_min  = sec_wrap;
            inc_hr   = sec_wrap && min_wrap;
            day_co_d = sec_wrap && min_wrap && hr_wrap;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      SET_HR: begin
        presc_d = '0;
        if (btn_mode)     state_d = SET_MIN;
        else if (btn_inc) inc_hr  = 1'b1;
      end
      SET_MIN: begin
        presc_d = '0;
        if (btn_mode) begin
          state_d  = RUN;
          sec_lo_d = '0;
          sec_hi_d = '0;
        end else if (btn_inc) begin
          inc_min = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        presc_d = '0;
      end
    endcase

    if (inc_min) begin
      if (min_lo_q != 4'd9) begin
        min_lo_d = min_lo_q + 4'd1;
      end else begin
        min_lo_d = '0;
        min_hi_d = (min_hi_q == 4'd5) ? 4'd0 : min_hi_q + 4'd1;
      end
    end

    if (inc_hr) begin
      if (hr_wrap) begin
        hr_lo_d = '0;
        hr_hi_d = '0;
      end else if (hr_lo_q == 4'd9) begin
        hr_lo_d = '0;
        hr_hi_d = hr_hi_q + 4'd1;
      end else begin
        hr_lo_d = hr_lo_q + 4'd1;
      end
    end
  end

  // State register; synchronous reset clears time, prescaler and mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      presc_q  <= '0;
      sec_lo_q <= '0;
      sec_hi_q <= '0;
      min_lo_q <= '0;
      min_hi_q <= '0;
      hr_lo_q  <= '0;
      hr_hi_q  <= '0;
      tick_q   <= 1'b0;
      day_co_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      sec_lo_q <= sec_lo_d;
      sec_hi_q <= sec_hi_d;
      min_lo_q <= min_lo_d;
      min_hi_q <= min_hi_d;
      hr_lo_q  <= hr_lo_d;
      hr_hi_q  <= hr_hi_d;
      tick_q   <= tick_d;
      day_co_q <= day_co_d;
    end
  end

  assign sec_lo = sec_lo_q;
  assign sec_hi = sec_hi_q;
  assign min_lo = min_lo_q;
  assign min_hi = min_hi_q;
  assign hr_lo  = hr_lo_q;
  assign hr_hi  = hr_hi_q;
  assign mode   = state_q;
  assign tick   = tick_q;
  assign day_co = day_co_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl with a 4-cycle seconds tick. Expected times come
// from a seconds-since-midnight model converted to BCD.
module tb_clock_time_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_en = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
  logic [1:0] mode;
  logic       tick, day_co;

  int checks = 0;
  int errors = 0;
  int model_secs = 0;

  typedef struct {
    logic [23:0] t;
    logic        dc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  clock_time_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
    .hr_lo(hr_lo), .hr_hi(hr_hi), .mode(mode), .tick(tick), .day_co(day_co)
  );

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic logic [23:0] shown();
    return {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue n expected ticks, then consume them: the first after first_gap edges,
  // the rest every TD edges, with no tick/day_co in between.
  task automatic run_ticks(input int n, input int first_gap);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      model_secs = (model_secs + 1) % 86400;
      e.t  = to_bcd(model_secs);
      e.dc = (model_secs == 0);
      sb.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int gap;
      gap = (k == 0) ? first_gap : TD;
      for (int c = 1; c <= gap; c++) begin
        step();
        if (c < gap) begin
          checks++;
          if (tick !== 1'b0 || day_co !== 1'b0) begin
            errors++;
            $display("FAIL tick_early: tick=%b day_co=%b required 0 0 (tick %0d cycle %0d)",
                     tick, day_co, k, c);
          end
        end
      end
      e = sb.pop_front();
      checks++;
      if (tick !== 1'b1) begin
        errors++;
        $display("FAIL tick_missing: tick=%b required 1 (tick %0d)", tick, k);
      end
      checks++;
      if (shown() !== e.t) begin
        errors++;
        $display("FAIL tick_time: got %h required %h", shown(), e.t);
      end
      checks++;
      if (day_co !== e.dc) begin
        errors++;
        $display("FAIL day_co: got %b required %b at %h", day_co, e.dc, e.t);
      end
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1'b1;
      step();
      btn_inc = 1'b0;
      checks++;
      if (tick !== 1'b0 || day_co !== 1'b0) begin
        errors++;
        $display("FAIL set_no_tick: tick=%b day_co=%b required 0 0", tick, day_co);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run_en = 1'b0;
    step();
    step();
    checks++;
    if (shown() !== 24'h0 || mode !== 2'd0 || tick !== 1'b0 || day_co !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: time=%h mode=%0d tick=%b day_co=%b required 000000 0 0 0",
               shown(), mode, tick, day_co);
    end
    rst = 1'b0;
    run_en = 1'b1;
    model_secs = 0;
  endtask

  task automatic test_first_ticks();
    run_ticks(1, TD);
    run_ticks(9, TD);
    checks++;
    if (shown() !== 24'h000010) begin
      errors++;
      $display("FAIL ten_ticks: got %h required 000010", shown());
    end
  endtask

  task automatic test_minute_carry();
    run_ticks(50, TD);
    checks++;
    if (shown() !== 24'h000100) begin
      errors++;
      $display("FAIL minute_carry: got %h required 000100", shown());
    end
  endtask

  task automatic test_set_time();
    run_ticks(7, TD);
    press_mode();
    checks++;
    if (mode !== 2'd1) begin
      errors++;
      $display("FAIL enter_set_hr: mode=%0d required 1", mode);
    end
    press_inc(23);
    checks++;
    if (shown() !== 24'h230107) begin
      errors++;
      $display("FAIL set_hours: got %h required 230107", shown());
    end
    press_mode();
    checks++;
    if (mode !== 2'd2 || shown() !== 24'h230107) begin
      errors++;
      $display("FAIL enter_set_min: mode=%0d time=%h required 2 230107", mode, shown());
    end
    press_inc(58);
    press_mode();
    checks++;
    if (mode !== 2'd0 || shown() !== 24'h235900) begin
      errors++;
      $display("FAIL exit_set: mode=%0d time=%h required 0 235900", mode, shown());
    end
    model_secs = 23 * 3600 + 59 * 60;
    run_ticks(60, TD);
    checks++;
    if (shown() !== 24'h000000) begin
      errors++;
      $display("FAIL day_rollover: got %h required 000000", shown());
    end
  endtask

  task automatic test_set_wrap();
    press_mode();
    press_inc(23);
    press_inc(1);
    checks++;
    if (shown() !== 24'h000000) begin
      errors++;
      $display("FAIL hour_wrap: got %h required 000000", shown());
    end
    press_inc(5);
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    step();
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    checks++;
    if (mode !== 2'd2 || shown() !== 24'h050000) begin
      errors++;
      $display("FAIL mode_and_inc: mode=%0d time=%h required 2 050000", mode, shown());
    end
    press_inc(59);
    checks++;
    if (shown() !== 24'h055900) begin
      errors++;
      $display("FAIL set_min59: got %h required 055900", shown());
    end
    press_inc(1);
    checks++;
    if (shown() !== 24'h050000) begin
      errors++;
      $display("FAIL min_wrap_no_carry: got %h required 050000", shown());
    end
    press_mode();
    model_secs = 5 * 3600;
  endtask

  task automatic test_run_inc_ignored();
    btn_inc = 1'b1;
    step();
    btn_inc = 1'b0;
    checks++;
    if (mode !== 2'd0 || shown() !== 24'h050000 || tick !== 1'b0) begin
      errors++;
      $display("FAIL run_inc: mode=%0d time=%h tick=%b required 0 050000 0", mode, shown(), tick);
    end
    run_ticks(2, TD - 1);
  endtask

  task automatic test_run_hold();
    step();
    step();
    run_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (tick !== 1'b0 || shown() !== 24'h050002) begin
        errors++;
        $display("FAIL hold: tick=%b time=%h required 0 050002", tick, shown());
      end
    end
    run_en = 1'b1;
    run_ticks(1, 2);
  endtask

  task automatic test_reset_mid_set();
    press_mode();
    press_mode();
    press_inc(3);
    rst = 1'b1;
    btn_inc = 1'b1;
    step();
    rst = 1'b0;
    btn_inc = 1'b0;
    checks++;
    if (shown() !== 24'h0 || mode !== 2'd0 || tick !== 1'b0 || day_co !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_set: time=%h mode=%0d tick=%b day_co=%b required 000000 0 0 0",
               shown(), mode, tick, day_co);
    end
    model_secs = 0;
    run_ticks(2, TD);
  endtask

  initial begin
    test_reset();
    test_first_ticks();
    test_minute_carry();
    test_set_time();
    test_set_wrap();
    test_run_inc_ignored();
    test_run_hold();
    test_reset_mid_set();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
